// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: drives the per-stage
// enable/clear pairs and PC enable, and keeps saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [1:0]       reg_read_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_to_reg_EX,
    input  logic             redirect_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt,
    input  logic             step,
    input  logic             stat_clr,
    output logic             pc_en,
    output logic             en_IF,
    output logic             clear_IF,
    output logic             en_EX,
    output logic             clear_EX,
    output logic             en_MEM,
    output logic             clear_MEM,
    output logic             en_WB,
    output logic             clear_WB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err,
    output logic             halted
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Bit order: {pc_en, en_IF, clear_IF, en_EX, clear_EX, en_MEM, clear_MEM, en_WB, clear_WB}
    localparam logic [8:0] CTL_NORMAL   = 9'b1_10_10_10_10;
    localparam logic [8:0] CTL_MSTALL   = 9'b0_00_00_00_11;
    localparam logic [8:0] CTL_REDIRECT = 9'b1_11_11_10_10;
    localparam logic [8:0] CTL_LOADUSE  = 9'b0_00_11_10_10;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic              timeout, mstall, loaduse, active;
    logic              rs1_hit, rs2_hit;
    logic [8:0]        ctl_next;
    logic [1:0]        stat_inc;

    assign timeout = (state_reg == ST_MEM_WAIT) && (wait_cnt_reg == WAIT_LAST);
    assign mstall  = dmem_req && !dmem_ready && !timeout;
    assign rs1_hit = reg_read_ID[0] && (rs1_ID == rd_EX);
    assign rs2_hit = reg_read_ID[1] && (rs2_ID == rd_EX);
    assign loaduse = mem_to_reg_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);
    // A step pulse lends one cycle of RUN behaviour to the HALT state.
    assign active  = (state_reg != ST_HALT) || step;

    always_comb begin
        ctl_next   = '0;
        state_next = state_reg;
        if (active) begin
            if (mstall)           ctl_next = CTL_MSTALL;
            else if (redirect_EX) ctl_next = CTL_REDIRECT;
            else if (loaduse)     ctl_next = CTL_LOADUSE;
            else                  ctl_next = CTL_NORMAL;
        end
        case (state_reg)
            ST_RUN: begin
                if (mstall)    state_next = ST_MEM_WAIT;
                else if (halt) state_next = ST_HALT;
            end
            ST_MEM_WAIT: begin
                if (!mstall) state_next = halt ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (step && mstall) state_next = ST_MEM_WAIT;
                else if (!halt)     state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign {pc_en, en_IF, clear_IF, en_EX, clear_EX, en_MEM, clear_MEM, en_WB, clear_WB} =
        rstn ? ctl_next : 9'b0;

    assign wait_cnt_next = (state_reg == ST_MEM_WAIT) ? wait_cnt_reg + WAIT_W'(1) : '0;
    assign mem_err_next  = stat_clr ? 1'b0 : (mem_err_reg || timeout);
    assign stat_inc      = {active && !mstall && redirect_EX, active && !ctl_next[8]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    // Index 0 counts stall cycles, index 1 counts applied redirects.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [CNT_W-1:0] cnt_reg, cnt_next;

        always_comb begin
            cnt_next = cnt_reg;
            if (stat_clr)
                cnt_next = '0;
            else if (stat_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                cnt_next = cnt_reg + CNT_W'(1);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) cnt_reg <= '0;
            else       cnt_reg <= cnt_next;
        end
    end

    assign stall_cnt = g_stat[0].cnt_reg;
    assign flush_cnt = g_stat[1].cnt_reg;
    assign mem_err   = mem_err_reg;
    assign halted    = (state_reg == ST_HALT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a rule-level reference model of the sequencing behaviour.
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam logic [8:0] C_NORM  = 9'b110101010;
    localparam logic [8:0] C_MST   = 9'b000000011;
    localparam logic [8:0] C_REDIR = 9'b111111010;
    localparam logic [8:0] C_LU    = 9'b000111010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, mem_to_reg_EX, redirect_EX, dmem_req, dmem_ready, halt, step, stat_clr;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic [1:0] reg_read_ID;

    logic pc_en, en_IF, clear_IF, en_EX, clear_EX, en_MEM, clear_MEM, en_WB, clear_WB;
    logic [15:0] stall_cnt, flush_cnt;
    logic mem_err, halted;

    logic s_pc_en, s_en_IF, s_clear_IF, s_en_EX, s_clear_EX, s_en_MEM, s_clear_MEM, s_en_WB, s_clear_WB;
    logic [3:0] s_stall_cnt, s_flush_cnt;
    logic s_mem_err, s_halted;

    hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rstn(rstn), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .reg_read_ID(reg_read_ID),
        .rd_EX(rd_EX), .mem_to_reg_EX(mem_to_reg_EX), .redirect_EX(redirect_EX),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt(halt), .step(step), .stat_clr(stat_clr),
        .pc_en(pc_en), .en_IF(en_IF), .clear_IF(clear_IF), .en_EX(en_EX), .clear_EX(clear_EX),
        .en_MEM(en_MEM), .clear_MEM(clear_MEM), .en_WB(en_WB), .clear_WB(clear_WB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err), .halted(halted)
    );

    // Narrow-counter instance on the same inputs, used to reach saturation cheaply.
    hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(MT)) dut_small (
        .clk(clk), .rstn(rstn), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .reg_read_ID(reg_read_ID),
        .rd_EX(rd_EX), .mem_to_reg_EX(mem_to_reg_EX), .redirect_EX(redirect_EX),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt(halt), .step(step), .stat_clr(stat_clr),
        .pc_en(s_pc_en), .en_IF(s_en_IF), .clear_IF(s_clear_IF), .en_EX(s_en_EX), .clear_EX(s_clear_EX),
        .en_MEM(s_en_MEM), .clear_MEM(s_clear_MEM), .en_WB(s_en_WB), .clear_WB(s_clear_WB),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .mem_err(s_mem_err), .halted(s_halted)
    );

    wire [8:0]  ctl = {pc_en, en_IF, clear_IF, en_EX, clear_EX, en_MEM, clear_MEM, en_WB, clear_WB};
    wire [8:0]  s_ctl = {s_pc_en, s_en_IF, s_clear_IF, s_en_EX, s_clear_EX, s_en_MEM, s_clear_MEM,
                         s_en_WB, s_clear_WB};
    wire [50:0] obs = {ctl, halted, mem_err, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = halted.
    int m_state, m_wait, m_stall, m_flush, s_stall, s_flush;
    bit m_err;

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; s_stall = 0; s_flush = 0; m_err = 0;
    endtask

    function automatic bit f_tmo();
        return (m_state == 1) && (m_wait == MT - 1);
    endfunction

    function automatic bit f_ms();
        return dmem_req && !dmem_ready && !f_tmo();
    endfunction

    function automatic bit f_lu();
        return mem_to_reg_EX && (rd_EX != 0) &&
               ((reg_read_ID[0] && rs1_ID == rd_EX) || (reg_read_ID[1] && rs2_ID == rd_EX));
    endfunction

    function automatic bit f_act();
        return (m_state != 2) || step;
    endfunction

    function automatic logic [8:0] exp_ctl();
        if (!rstn || !f_act()) return 9'b0;
        if (f_ms())            return C_MST;
        if (redirect_EX)       return C_REDIR;
        if (f_lu())            return C_LU;
        return C_NORM;
    endfunction

    function automatic logic [50:0] exp_all();
        logic [15:0] a, b;
        logic [3:0]  c, d;
        a = m_stall[15:0]; b = m_flush[15:0]; c = s_stall[3:0]; d = s_flush[3:0];
        return {exp_ctl(), (m_state == 2), m_err, a, b, c, d};
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic tick(input string tag);
        bit tmo, ms, act;
        logic [8:0] e;
        int ns;
        tmo = f_tmo(); ms = f_ms(); act = f_act(); e = exp_ctl();
        $display("%s cyc=%0d mode=%0d ctl=%b stall=%0d flush=%0d err=%0b halted=%0b",
                 tag, cyc, m_state, ctl, stall_cnt, flush_cnt, mem_err, halted);
        if (stat_clr) begin
            m_stall = 0; m_flush = 0; s_stall = 0; s_flush = 0; m_err = 0;
        end else begin
            if (act && !e[8]) begin
                if (m_stall < 65535) m_stall++;
                if (s_stall < 15)    s_stall++;
            end
            if (act && !ms && redirect_EX) begin
                if (m_flush < 65535) m_flush++;
                if (s_flush < 15)    s_flush++;
            end
            if (tmo) m_err = 1;
        end
        ns = (act && ms) ? 1 : (halt ? 2 : 0);
        m_wait  = (m_state == 1) ? m_wait + 1 : 0;
        m_state = ns;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; reg_read_ID = 0; rd_EX = 0; mem_to_reg_EX = 0; redirect_EX = 0;
        dmem_req = 0; dmem_ready = 0; halt = 0; step = 0; stat_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        dmem_req = 1; redirect_EX = 1; rstn = 0;
        #2;
        model_reset();
        n_checks++;
        if (ctl !== 9'b0) $display("FAIL reset_ctl got=%b want=%b", ctl, 9'b0); else n_pass++;
        n_checks++;
        if ({halted, mem_err, stall_cnt, flush_cnt} !== 34'b0)
            $display("FAIL reset_state got=%b/%b/%0d/%0d want=0", halted, mem_err, stall_cnt, flush_cnt);
        else n_pass++;
        @(posedge clk); #1;
        idle(); rstn = 1; #3;
        n_checks++;
        if (obs !== exp_all()) $display("FAIL reset_release got=%h want=%h", obs, exp_all()); else n_pass++;
        tick("reset");
    endtask

    task automatic test_load_use();
        idle(); mem_to_reg_EX = 1; rd_EX = 5; rs1_ID = 5; reg_read_ID = 2'b01; #3;
        n_checks++;
        if (ctl !== C_LU) $display("FAIL loaduse_rs1 got=%b want=%b", ctl, C_LU); else n_pass++;
        tick("loaduse");
        mem_to_reg_EX = 0; #3;
        n_checks++;
        if (ctl !== C_NORM) $display("FAIL loaduse_after got=%b want=%b", ctl, C_NORM); else n_pass++;
        n_checks++;
        if (stall_cnt !== 16'd1) $display("FAIL loaduse_cnt got=%0d want=1", stall_cnt); else n_pass++;
        tick("loaduse");
        mem_to_reg_EX = 1; rd_EX = 0; rs1_ID = 0; #3;
        n_checks++;
        if (ctl !== C_NORM) $display("FAIL loaduse_x0 got=%b want=%b", ctl, C_NORM); else n_pass++;
        tick("loaduse");
        rd_EX = 5; rs1_ID = 5; reg_read_ID = 2'b00; #3;
        n_checks++;
        if (ctl !== C_NORM) $display("FAIL loaduse_unused got=%b want=%b", ctl, C_NORM); else n_pass++;
        tick("loaduse");
        rs1_ID = 3; rs2_ID = 5; reg_read_ID = 2'b10; #3;
        n_checks++;
        if (obs !== exp_all()) $display("FAIL loaduse_rs2 got=%h want=%h", obs, exp_all()); else n_pass++;
        tick("loaduse");
    endtask

    task automatic test_redirect();
        int f0, s0;
        idle(); f0 = m_flush; s0 = m_stall;
        redirect_EX = 1; mem_to_reg_EX = 1; rd_EX = 7; rs1_ID = 7; reg_read_ID = 2'b01; #3;
        n_checks++;
        if (ctl !== C_REDIR) $display("FAIL redirect_prio got=%b want=%b", ctl, C_REDIR); else n_pass++;
        tick("redirect");
        idle(); #3;
        n_checks++;
        if (flush_cnt !== 16'(f0 + 1) || stall_cnt !== 16'(s0))
            $display("FAIL redirect_cnt got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
        else n_pass++;
        tick("redirect");
    endtask

    task automatic test_mem_wait();
        int s0;
        idle(); s0 = m_stall; dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (ctl !== C_MST) $display("FAIL memwait_frozen%0d got=%b want=%b", i, ctl, C_MST); else n_pass++;
            tick("memwait");
        end
        dmem_ready = 1; #3;
        n_checks++;
        if (ctl !== C_NORM) $display("FAIL memwait_release got=%b want=%b", ctl, C_NORM); else n_pass++;
        tick("memwait");
        idle(); #3;
        n_checks++;
        if (stall_cnt !== 16'(s0 + 3) || halted !== 1'b0)
            $display("FAIL memwait_cnt got=%0d/%b want=%0d/0", stall_cnt, halted, s0 + 3);
        else n_pass++;
        tick("memwait");
        // Redirect and halt raised while memory is stalled are deferred to the release cycle.
        dmem_req = 1; redirect_EX = 1; halt = 1;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++;
            if (obs !== exp_all()) $display("FAIL memwait_defer%0d got=%h want=%h", i, obs, exp_all()); else n_pass++;
            tick("memwait");
        end
        dmem_ready = 1; #3;
        n_checks++;
        if (ctl !== C_REDIR || halted !== 1'b0)
            $display("FAIL memwait_redir got=%b/%b want=%b/0", ctl, halted, C_REDIR);
        else n_pass++;
        tick("memwait");
        dmem_req = 0; dmem_ready = 0; redirect_EX = 0; #3;
        n_checks++;
        if (ctl !== 9'b0 || halted !== 1'b1) $display("FAIL memwait_halt got=%b/%b want=0/1", ctl, halted); else n_pass++;
        tick("memwait");
        halt = 0; tick("memwait");
    endtask

    task automatic test_timeout();
        idle(); dmem_req = 1;
        for (int i = 0; i < MT; i++) begin
            #3;
            n_checks++;
            if (ctl !== C_MST) $display("FAIL timeout_frozen%0d got=%b want=%b", i, ctl, C_MST); else n_pass++;
            tick("timeout");
        end
        #3;
        n_checks++;
        if (ctl !== C_NORM) $display("FAIL timeout_release got=%b want=%b", ctl, C_NORM); else n_pass++;
        tick("timeout");
        dmem_req = 0;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++;
            if (mem_err !== 1'b1) $display("FAIL timeout_err%0d got=%b want=1", i, mem_err); else n_pass++;
            tick("timeout");
        end
        stat_clr = 1; tick("timeout");
        stat_clr = 0; #3;
        n_checks++;
        if ({mem_err, stall_cnt, flush_cnt} !== 33'b0)
            $display("FAIL timeout_clr got=%b/%0d/%0d want=0/0/0", mem_err, stall_cnt, flush_cnt);
        else n_pass++;
        tick("timeout");
    endtask

    task automatic test_halt();
        int s0;
        idle(); halt = 1; #3;
        n_checks++;
        if (ctl !== C_NORM || halted !== 1'b0) $display("FAIL halt_enter got=%b/%b want=%b/0", ctl, halted, C_NORM); else n_pass++;
        tick("halt");
        s0 = m_stall;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++;
            if (ctl !== 9'b0 || halted !== 1'b1) $display("FAIL halt_idle%0d got=%b/%b want=0/1", i, ctl, halted); else n_pass++;
            tick("halt");
        end
        step = 1; #3;
        n_checks++;
        if (ctl !== C_NORM || halted !== 1'b1) $display("FAIL halt_step got=%b/%b want=%b/1", ctl, halted, C_NORM); else n_pass++;
        tick("halt");
        step = 0; #3;
        n_checks++;
        if (ctl !== 9'b0 || halted !== 1'b1 || stall_cnt !== 16'(s0))
            $display("FAIL halt_after_step got=%b/%b/%0d want=0/1/%0d", ctl, halted, stall_cnt, s0);
        else n_pass++;
        tick("halt");
        step = 1; mem_to_reg_EX = 1; rd_EX = 9; rs2_ID = 9; reg_read_ID = 2'b10; #3;
        n_checks++;
        if (obs !== exp_all()) $display("FAIL halt_step_lu got=%h want=%h", obs, exp_all()); else n_pass++;
        tick("halt");
        step = 1; mem_to_reg_EX = 0; dmem_req = 1; #3;
        n_checks++;
        if (ctl !== C_MST) $display("FAIL halt_step_mem got=%b want=%b", ctl, C_MST); else n_pass++;
        tick("halt");
        step = 0;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2); #3;
            n_checks++;
            if (obs !== exp_all()) $display("FAIL halt_wait%0d got=%h want=%h", i, obs, exp_all()); else n_pass++;
            tick("halt");
        end
        idle(); #3;
        n_checks++;
        if (ctl !== 9'b0 || halted !== 1'b1) $display("FAIL halt_drop got=%b/%b want=0/1", ctl, halted); else n_pass++;
        tick("halt");
        #3;
        n_checks++;
        if (ctl !== C_NORM || halted !== 1'b0) $display("FAIL halt_resume got=%b/%b want=%b/0", ctl, halted, C_NORM); else n_pass++;
        tick("halt");
    endtask

    task automatic test_reset_mid_wait();
        idle(); dmem_req = 1;
        tick("rstwait"); tick("rstwait");
        #2; rstn = 0; #1;
        model_reset();
        n_checks++;
        if (ctl !== 9'b0 || halted !== 1'b0) $display("FAIL rstwait_force got=%b/%b want=0/0", ctl, halted); else n_pass++;
        @(posedge clk); #1;
        rstn = 1; dmem_req = 0;
        for (int i = 0; i < MT + 1; i++) begin
            #3;
            n_checks++;
            if (obs !== exp_all()) $display("FAIL rstwait_run%0d got=%h want=%h", i, obs, exp_all()); else n_pass++;
            tick("rstwait");
        end
    endtask

    task automatic test_saturation();
        idle(); stat_clr = 1; tick("sat");
        stat_clr = 0; mem_to_reg_EX = 1; rd_EX = 4; rs1_ID = 4; reg_read_ID = 2'b01;
        repeat (20) tick("sat");
        redirect_EX = 1;
        repeat (20) tick("sat");
        idle(); #3;
        n_checks++;
        if (s_stall_cnt !== 4'hF || s_flush_cnt !== 4'hF)
            $display("FAIL sat_small got=%h/%h want=f/f", s_stall_cnt, s_flush_cnt);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 16'd20 || flush_cnt !== 16'd20)
            $display("FAIL sat_wide got=%0d/%0d want=20/20", stall_cnt, flush_cnt);
        else n_pass++;
        n_checks++;
        if (s_ctl !== ctl) $display("FAIL sat_ctl_match got=%b want=%b", s_ctl, ctl); else n_pass++;
        tick("sat");
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 500; i++) begin
            rs1_ID        = 5'($urandom_range(0, 3));
            rs2_ID        = 5'($urandom_range(0, 3));
            rd_EX         = 5'($urandom_range(0, 3));
            reg_read_ID   = 2'($urandom_range(0, 3));
            mem_to_reg_EX = ($urandom_range(0, 1) == 1);
            redirect_EX   = ($urandom_range(0, 4) == 0);
            dmem_req      = (m_state == 1) || ($urandom_range(0, 3) == 0);
            dmem_ready    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) halt = !halt;
            step          = ($urandom_range(0, 5) == 0);
            stat_clr      = ($urandom_range(0, 60) == 0);
            #3;
            n_checks++;
            if (obs !== exp_all()) $display("FAIL random%0d got=%h want=%h", i, obs, exp_all()); else n_pass++;
            tick("random");
        end
    endtask

    initial begin
        idle();
        rstn = 0;
        model_reset();
        #12;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
